// File: rtl/rsa_modexp_engine_pkg.sv
// Shared types and constants for the modular-exponentiation engine.
package rsa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_MUL,
    ST_SQR,
    ST_DONE
  } state_e;

  localparam logic ERR_NONE    = 1'b0;
  localparam logic ERR_OPERAND = 1'b1;

  // Cycles from operand accept to out_valid for a given exponent.
  function automatic int unsigned modexp_latency(input int unsigned width,
                                                 input logic [63:0] e,
                                                 input logic operand_err);
    int unsigned k;
    int unsigned h;
    k = 0;
    h = 0;
    if (operand_err || e == '0) return 2;
    for (int unsigned i = 0; i < 64; i++) begin
      if (e[i]) begin
        h++;
        k = i;
      end
    end
    return 1 + (h + k) * (width + 1) + 1;
  endfunction

endpackage

// File: rtl/rsa_modexp_engine_if.sv
// Operand/result handshake bundle for rsa_modexp_engine.
interface rsa_modexp_engine_if #(
  parameter int unsigned WIDTH     = 1024,
  parameter int unsigned EXP_WIDTH = 1024
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_base;
  logic [EXP_WIDTH-1:0] in_exp;
  logic [WIDTH-1:0]     in_mod;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_result;
  logic                 out_error;

  modport master (
    output in_valid, in_base, in_exp, in_mod, out_ready,
    input  in_ready, out_valid, out_result, out_error
  );

  modport slave (
    input  in_valid, in_base, in_exp, in_mod, out_ready,
    output in_ready, out_valid, out_result, out_error
  );
endinterface

// File: rtl/rsa_modexp_engine_mod_mul_serial.sv
// Serial interleaved modular multiplier: p = a*b mod n, one bit of a per cycle, MSB first.
module mod_mul_serial #(
  parameter int unsigned WIDTH = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             done,
  output logic [WIDTH-1:0] p
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] acc_q, a_q, b_q, n_q;
  logic [CW-1:0]    cnt_q;
  logic             run_q;

  logic [WIDTH-1:0] acc_cur, b_cur, n_cur;
  logic             bit_cur;
  logic [WIDTH+1:0] t;

  // The start cycle performs the first iteration on the live inputs so done lands WIDTH cycles later.
  always_comb begin
    acc_cur = start ? '0 : acc_q;
    bit_cur = start ? a[WIDTH-1] : a_q[WIDTH-1];
    b_cur   = start ? b : b_q;
    n_cur   = start ? n : n_q;
    t = {1'b0, acc_cur, 1'b0} + (bit_cur ? {2'b00, b_cur} : '0);
    if (t >= {2'b00, n_cur}) t = t - {2'b00, n_cur};
    if (t >= {2'b00, n_cur}) t = t - {2'b00, n_cur};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      n_q   <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc_q <= t[WIDTH-1:0];
        a_q   <= a << 1;
        b_q   <= b;
        n_q   <= n;
        cnt_q <= CW'(WIDTH - 1);
        run_q <= 1'b1;
      end else if (run_q) begin
        acc_q <= t[WIDTH-1:0];
        a_q   <= a_q << 1;
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          run_q <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

  assign p = acc_q;

endmodule

// File: rtl/rsa_modexp_engine.sv
// Right-to-left square-and-multiply modular exponentiation over one shared serial multiplier.
module rsa_modexp_engine
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH     = 1024,
  parameter int unsigned EXP_WIDTH = 1024
) (
  input  logic                aclk,
  input  logic                aresetn,
  rsa_modexp_engine_if.slave  s,
  output logic                busy
);
  state_e state_q, state_d;

  logic [WIDTH-1:0]     b_q, r_q, n_q, res_q;
  logic [EXP_WIDTH-1:0] e_q, e_shr;
  logic                 err_q;
  logic                 mul_run_q, mul_start, mul_done;
  logic [WIDTH-1:0]     mul_a, mul_p;
  logic                 in_ready, accept, operand_bad;

  assign in_ready    = aresetn && (state_q == ST_IDLE);
  assign accept      = s.in_valid && in_ready;
  assign operand_bad = (n_q < WIDTH'(2)) || (b_q >= n_q);
  assign e_shr       = e_q >> 1;
  assign mul_a       = (state_q == ST_SQR) ? b_q : r_q;

  mod_mul_serial #(.WIDTH(WIDTH)) u_mul (
    .clk   (aclk),
    .rst_n (aresetn),
    .start (mul_start),
    .a     (mul_a),
    .b     (b_q),
    .n     (n_q),
    .done  (mul_done),
    .p     (mul_p)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Zero exponent bits never occupy a MUL cycle: CHECK and SQR shift them out directly and go on squaring.
  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_CHECK;
      ST_CHECK: begin
        if (operand_bad || e_q == '0) state_d = ST_DONE;
        else if (e_q[0])              state_d = ST_MUL;
        else                          state_d = ST_SQR;
      end
      ST_MUL: begin
        mul_start = !mul_run_q;
        if (mul_done) state_d = (e_shr == '0) ? ST_DONE : ST_SQR;
      end
      ST_SQR: begin
        mul_start = !mul_run_q;
        if (mul_done) state_d = e_q[0] ? ST_MUL : ST_SQR;
      end
      ST_DONE:  if (s.out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      b_q       <= '0;
      r_q       <= '0;
      n_q       <= '0;
      e_q       <= '0;
      res_q     <= '0;
      err_q     <= ERR_NONE;
      mul_run_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) begin
          b_q <= s.in_base;
          e_q <= s.in_exp;
          n_q <= s.in_mod;
          r_q <= WIDTH'(1);
        end
        ST_CHECK: begin
          if (operand_bad) begin
            res_q <= '0;
            err_q <= ERR_OPERAND;
          end else if (e_q == '0) begin
            res_q <= WIDTH'(1);
            err_q <= ERR_NONE;
          end else if (!e_q[0]) begin
            e_q <= e_shr;
          end
        end
        ST_MUL: begin
          if (mul_start) mul_run_q <= 1'b1;
          if (mul_done) begin
            mul_run_q <= 1'b0;
            r_q       <= mul_p;
            e_q       <= e_shr;
            if (e_shr == '0) begin
              res_q <= mul_p;
              err_q <= ERR_NONE;
            end
          end
        end
        ST_SQR: begin
          if (mul_start) mul_run_q <= 1'b1;
          if (mul_done) begin
            mul_run_q <= 1'b0;
            b_q       <= mul_p;
            if (!e_q[0]) e_q <= e_shr;
          end
        end
        default: ;
      endcase
    end
  end

  assign s.in_ready   = in_ready;
  assign s.out_valid  = aresetn && (state_q == ST_DONE);
  assign s.out_result = res_q;
  assign s.out_error  = err_q;
  assign busy         = aresetn && (state_q != ST_IDLE);

endmodule

// File: tb/tb_rsa_modexp_engine.sv
// Bench for rsa_modexp_engine: directed and random operands against an arithmetic reference model.
module tb_rsa_modexp_engine;

  logic aclk;
  logic aresetn;
  logic sel;
  logic out_rdy;
  logic rand_rdy;
  logic busy16, busy1k;
  int unsigned cyc;
  int unsigned n_cmp;
  int unsigned n_fail;

  rsa_modexp_engine_if #(.WIDTH(16),   .EXP_WIDTH(16)) if16 ();
  rsa_modexp_engine_if #(.WIDTH(1024), .EXP_WIDTH(17)) if1k ();

  rsa_modexp_engine #(.WIDTH(16), .EXP_WIDTH(16)) dut16 (
    .aclk(aclk), .aresetn(aresetn), .s(if16), .busy(busy16));
  rsa_modexp_engine #(.WIDTH(1024), .EXP_WIDTH(17)) dut1k (
    .aclk(aclk), .aresetn(aresetn), .s(if1k), .busy(busy1k));

  assign if16.out_ready = out_rdy;
  assign if1k.out_ready = out_rdy;

  // Monitor view of whichever instance is active.
  logic          m_in_valid, m_in_ready, m_out_valid, m_out_ready, m_err, m_busy;
  logic [1023:0] m_base, m_mod, m_res;
  logic [31:0]   m_exp;
  int unsigned   m_width;
  assign m_in_valid  = sel ? if1k.in_valid  : if16.in_valid;
  assign m_in_ready  = sel ? if1k.in_ready  : if16.in_ready;
  assign m_out_valid = sel ? if1k.out_valid : if16.out_valid;
  assign m_out_ready = out_rdy;
  assign m_err       = sel ? if1k.out_error : if16.out_error;
  assign m_busy      = sel ? busy1k : busy16;
  assign m_base      = sel ? if1k.in_base    : 1024'(if16.in_base);
  assign m_mod       = sel ? if1k.in_mod     : 1024'(if16.in_mod);
  assign m_res       = sel ? if1k.out_result : 1024'(if16.out_result);
  assign m_exp       = sel ? 32'(if1k.in_exp) : 32'(if16.in_exp);
  assign m_width     = sel ? 1024 : 16;

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  always @(posedge aclk) cyc <= cyc + 1;

  // Left-to-right exponentiation with wide arithmetic, independent of the engine's bit order.
  function automatic logic [1023:0] ref_modexp(input logic [1023:0] b, input logic [31:0] e,
                                               input logic [1023:0] n);
    logic [2047:0] acc, bb, nn;
    acc = 2048'(1);
    bb  = {1024'b0, b};
    nn  = {1024'b0, n};
    for (int i = 31; i >= 0; i--) begin
      acc = (acc * acc) % nn;
      if (e[i]) acc = (acc * bb) % nn;
    end
    return acc[1023:0];
  endfunction

  task automatic chkw(input string name, input logic [1023:0] act, input logic [1023:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act[191:0], req[191:0]);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  typedef struct {
    logic [1023:0] res;
    logic          err;
    int unsigned   acc;
    int unsigned   lat;
  } exp_t;
  exp_t q[$];

  initial begin : compare
    bit   was_rst;
    bit   seen;
    logic err_m;
    exp_t e_new;
    was_rst = 1'b0;
    seen    = 1'b0;
    chkw("pin_4_13_497",      ref_modexp(1024'd4, 32'd13, 1024'd497), 1024'd445);
    chkw("pin_65_17_3233",    ref_modexp(1024'd65, 32'd17, 1024'd3233), 1024'd2790);
    chkw("pin_2790_2753",     ref_modexp(1024'd2790, 32'd2753, 1024'd3233), 1024'd65);
    chkw("pin_3_5_11",        ref_modexp(1024'd3, 32'd5, 1024'd11), 1024'd1);
    chkw("pin_lat_e13",       1024'(rsa_pkg::modexp_latency(16, 64'd13, 1'b0)), 1024'd104);
    chkw("pin_lat_e0",        1024'(rsa_pkg::modexp_latency(16, 64'd0, 1'b0)), 1024'd2);
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        chk1("rst_in_ready", m_in_ready, 1'b0);
        q.delete();
        seen    = 1'b0;
        was_rst = 1'b1;
      end else begin
        if (was_rst) begin
          chk1("rst_out_valid", m_out_valid, 1'b0);
          chk1("rst_busy", m_busy, 1'b0);
          chkw("rst_out_result", m_res, '0);
          chk1("rst_out_error", m_err, 1'b0);
          was_rst = 1'b0;
        end
        chk1("busy", m_busy, q.size() != 0);
        chk1("in_ready", m_in_ready, q.size() == 0);
        if (q.size() != 0) begin
          if (m_out_valid) begin
            if (!seen) begin
              chkw("latency", 1024'(cyc - q[0].acc), 1024'(q[0].lat));
              seen = 1'b1;
            end
            chkw("out_result", m_res, q[0].res);
            chk1("out_error", m_err, q[0].err);
            if (m_out_ready) begin
              void'(q.pop_front());
              seen = 1'b0;
            end
          end else if (cyc - q[0].acc > q[0].lat + 4) begin
            chk1("result_timeout", m_out_valid, 1'b1);
            void'(q.pop_front());
            seen = 1'b0;
          end
        end else begin
          chk1("spurious_out_valid", m_out_valid, 1'b0);
        end
        if (m_in_valid && m_in_ready) begin
          err_m     = (m_mod < 1024'd2) || (m_base >= m_mod);
          e_new.err = err_m;
          e_new.res = err_m ? '0 : ref_modexp(m_base, m_exp, m_mod);
          e_new.acc = cyc;
          e_new.lat = rsa_pkg::modexp_latency(m_width, 64'(m_exp), err_m);
          q.push_back(e_new);
        end
      end
    end
  end

  task automatic drive_in(input logic v, input logic [1023:0] b, input logic [31:0] e,
                          input logic [1023:0] n);
    if (!sel) begin
      if16.in_valid = v;
      if16.in_base  = b[15:0];
      if16.in_exp   = e[15:0];
      if16.in_mod   = n[15:0];
    end else begin
      if1k.in_valid = v;
      if1k.in_base  = b;
      if1k.in_exp   = e[16:0];
      if1k.in_mod   = n;
    end
  endtask

  // Called at posedge+1; in_ready cannot change before the next edge.
  task automatic send(input logic [1023:0] b, input logic [31:0] e, input logic [1023:0] n);
    logic ok;
    drive_in(1'b1, b, e, n);
    for (int i = 0; i < 64; i++) begin
      ok = m_in_ready;
      @(posedge aclk);
      #1;
      if (ok) break;
    end
    drive_in(1'b0, b, e, n);
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(posedge aclk);
      #1;
      if (rand_rdy) out_rdy = 1'($urandom_range(0, 1));
      if (m_in_ready) break;
    end
  endtask

  logic [1023:0] rb, rm;
  logic [31:0]   re;

  initial begin : driver
    int r;
    aresetn  = 1'b0;
    sel      = 1'b0;
    out_rdy  = 1'b1;
    rand_rdy = 1'b0;
    cyc      = 0;
    n_cmp    = 0;
    n_fail   = 0;
    if16.in_valid = 1'b0; if16.in_base = '0; if16.in_exp = '0; if16.in_mod = '0;
    if1k.in_valid = 1'b0; if1k.in_base = '0; if1k.in_exp = '0; if1k.in_mod = '0;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk);
    #1;

    send(4, 13, 497);         wait_idle(300);
    send(65, 17, 3233);       wait_idle(300);
    send(2790, 2753, 3233);   wait_idle(400);
    send(5, 0, 7);            wait_idle(20);
    send(7, 3, 7);            wait_idle(20);
    send(3, 3, 1);            wait_idle(20);
    send(0, 3, 0);            wait_idle(20);
    send(6, 1, 7);            wait_idle(60);

    // Hold off the consumer after the result appears.
    out_rdy = 1'b0;
    send(3, 7, 13);
    for (int i = 0; i < 300; i++) begin
      @(posedge aclk);
      #1;
      if (m_out_valid) break;
    end
    repeat (20) @(posedge aclk);
    #1 out_rdy = 1'b1;
    wait_idle(20);

    // Reset while the first square of 2^5 mod 11 is in flight.
    send(2, 5, 11);
    repeat (20) @(posedge aclk);
    #1 aresetn = 1'b0;
    @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk);
    #1;
    send(3, 5, 11);           wait_idle(200);

    rand_rdy = 1'b1;
    for (int k = 0; k < 20; k++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) rm = 1024'($urandom_range(0, 1));
      else        rm = 1024'($urandom_range(2, 65535));
      if (r == 0)      rb = 1024'($urandom_range(0, 65535));
      else if (r == 1) rb = rm + 1024'($urandom_range(0, 65535 - int'(rm[15:0])));
      else             rb = 1024'($urandom % 32'(rm));
      re = 32'($urandom_range(0, 65535));
      send(rb, re, rm);
      wait_idle(700);
    end
    rand_rdy = 1'b0;
    out_rdy  = 1'b1;
    wait_idle(50);

    sel = 1'b1;
    @(posedge aclk);
    #1;
    rm = '0;
    rm[1023] = 1'b1;
    rm[0]    = 1'b1;
    send(rm, 65537, rm);      wait_idle(20);
    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < 32; w++) begin
        rm[w*32 +: 32] = $urandom;
        rb[w*32 +: 32] = $urandom;
      end
      rm[1023] = 1'b1;
      rm[0]    = 1'b1;
      rb = rb % rm;
      send(rb, 65537, rm);
      wait_idle(19000);
    end
    repeat (3) @(posedge aclk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
